// File: rtl/enemy_controller.sv
// Per-enemy chase / windup / strike / cooldown sequencer.
// Position, facing and attack flags are all registered, paced by the frame tick.
module enemy_controller #(
  parameter int         id              = 0,
  parameter logic [8:0] X_MIN           = 9'd16,
  parameter logic [8:0] X_MAX           = 9'd454,
  parameter logic [8:0] Y_MIN           = 9'd16,
  parameter logic [8:0] Y_MAX           = 9'd294,
  parameter logic [8:0] STEP            = 9'd1,
  parameter logic [8:0] ATTACK_RANGE    = 9'd20,
  parameter logic [5:0] WINDUP_FRAMES   = 6'd8,
  parameter logic [5:0] COOLDOWN_FRAMES = 6'd30,
  parameter logic [8:0] KNOCKBACK       = 9'd8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       game_frame_clk_rising_edge,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic       Enemy_Alive,
  input  logic       Enemy_Is_Attacked,
  input  logic       Enemy_Is_Attacked2,
  output logic [8:0] Enemy_X,
  output logic [8:0] Enemy_Y,
  output logic [1:0] Enemy_Direction,
  output logic       Enemy_Attack_On,
  output logic       Enemy_Attack_Valid,
  output logic [2:0] Enemy_State
);

  typedef enum logic [2:0] {
    DEAD     = 3'd0,
    CHASE    = 3'd1,
    WINDUP   = 3'd2,
    STRIKE   = 3'd3,
    COOLDOWN = 3'd4
  } state_e;

  localparam logic [1:0] ID_B    = id[1:0];
  localparam logic [8:0] SPAWN_X = ID_B[0] ? X_MAX : X_MIN;
  localparam logic [8:0] SPAWN_Y = ID_B[1] ? Y_MAX : Y_MIN;
  localparam logic [9:0] KB2_W   = {KNOCKBACK, 1'b0};
  localparam logic [8:0] KB2     = KB2_W[9] ? 9'h1FF : KB2_W[8:0];
  localparam logic [5:0] WU_LAST = WINDUP_FRAMES - 6'd1;
  localparam logic [5:0] CD_LAST = COOLDOWN_FRAMES - 6'd1;

  state_e     state_q, state_d;
  logic [8:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [1:0] dir_q, dir_d;
  logic [5:0] cnt_q, cnt_d;

  logic signed [9:0] dx, dy;
  logic [9:0]        adx, ady;
  logic              in_rng;
  logic              hit;
  logic [8:0]        kb;
  logic signed [11:0] xs, ys;

  function automatic logic [8:0] sat(
    input logic signed [11:0] v,
    input logic [8:0]         lo,
    input logic [8:0]         hi
  );
    logic signed [11:0] los, his;
    los = $signed({3'b000, lo});
    his = $signed({3'b000, hi});
    if (v < los)      sat = lo;
    else if (v > his) sat = hi;
    else              sat = v[8:0];
  endfunction

  assign dx     = $signed({1'b0, Player_X}) - $signed({1'b0, x_q});
  assign dy     = $signed({1'b0, Player_Y}) - $signed({1'b0, y_q});
  assign adx    = dx[9] ? 10'(-dx) : 10'(dx);
  assign ady    = dy[9] ? 10'(-dy) : 10'(dy);
  assign in_rng = (adx <= {1'b0, ATTACK_RANGE}) &&
                  (ady <= {1'b0, ATTACK_RANGE});
  assign hit    = Enemy_Is_Attacked | Enemy_Is_Attacked2;
  assign kb     = Enemy_Is_Attacked2 ? KB2 : KNOCKBACK;
  assign xs     = $signed({3'b000, x_q});
  assign ys     = $signed({3'b000, y_q});

  // Next-state: death override, then per-tick FSM, then knockback displacement
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (!Enemy_Alive) begin
      state_d = DEAD;
      x_d     = SPAWN_X;
      y_d     = SPAWN_Y;
      cnt_d   = '0;
    end else if (game_frame_clk_rising_edge) begin
      unique case (state_q)
        DEAD: state_d = CHASE;
        CHASE: begin
          if (in_rng) begin
            state_d = WINDUP;
            cnt_d   = '0;
          end else if (!hit) begin
            if (adx >= ady) begin
              if (dx[9]) begin
                x_d   = sat(xs - $signed({3'b000, STEP}), X_MIN, X_MAX);
                dir_d = 2'd1;
              end else begin
                x_d   = sat(xs + $signed({3'b000, STEP}), X_MIN, X_MAX);
                dir_d = 2'd3;
              end
            end else begin
              if (dy[9]) begin
                y_d   = sat(ys - $signed({3'b000, STEP}), Y_MIN, Y_MAX);
                dir_d = 2'd2;
              end else begin
                y_d   = sat(ys + $signed({3'b000, STEP}), Y_MIN, Y_MAX);
                dir_d = 2'd0;
              end
            end
          end
        end
        WINDUP: begin
          if (!in_rng || hit) begin
            state_d = CHASE;
            cnt_d   = '0;
          end else if (cnt_q == WU_LAST) begin
            state_d = STRIKE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        STRIKE: begin
          state_d = COOLDOWN;
          cnt_d   = '0;
        end
        COOLDOWN: begin
          if (cnt_q == CD_LAST) begin
            state_d = CHASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: state_d = DEAD;
      endcase
      if (hit && state_q != DEAD) begin
        unique case (dir_q)
          2'd0: y_d = sat(ys - $signed({3'b000, kb}), Y_MIN, Y_MAX);
          2'd1: x_d = sat(xs + $signed({3'b000, kb}), X_MIN, X_MAX);
          2'd2: y_d = sat(ys + $signed({3'b000, kb}), Y_MIN, Y_MAX);
          default: x_d = sat(xs - $signed({3'b000, kb}), X_MIN, X_MAX);
        endcase
      end
    end
  end

  // State, position, facing and frame counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= DEAD;
      x_q     <= SPAWN_X;
      y_q     <= SPAWN_Y;
      dir_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Enemy_X            = x_q;
  assign Enemy_Y            = y_q;
  assign Enemy_Direction    = dir_q;
  assign Enemy_State        = state_q;
  assign Enemy_Attack_On    = (state_q == WINDUP) || (state_q == STRIKE);
  assign Enemy_Attack_Valid = (state_q == STRIKE);

endmodule

// File: tb/tb_enemy_controller.sv
// Randomized bench for enemy_controller against an integer reference model.
// Directed scenarios first, then random ticks, hits, deaths and player moves.
module tb_enemy_controller;

  logic       Clk = 1'b0;
  logic       Reset, tick, Alive, A1, A2;
  logic [8:0] PX, PY;
  logic [8:0] ex, ey, ex3, ey3;
  logic [1:0] edir, edir3;
  logic       aon, aval, aon3, aval3;
  logic [2:0] est, est3;

  int nvec = 0;
  int nerr = 0;
  int mx, my, md, ms, mc;

  always #5 Clk = ~Clk;

  enemy_controller #(.id(0)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .game_frame_clk_rising_edge(tick),
    .Player_X(PX), .Player_Y(PY),
    .Enemy_Alive(Alive),
    .Enemy_Is_Attacked(A1), .Enemy_Is_Attacked2(A2),
    .Enemy_X(ex), .Enemy_Y(ey), .Enemy_Direction(edir),
    .Enemy_Attack_On(aon), .Enemy_Attack_Valid(aval),
    .Enemy_State(est)
  );

  enemy_controller #(.id(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset),
    .game_frame_clk_rising_edge(tick),
    .Player_X(PX), .Player_Y(PY),
    .Enemy_Alive(Alive),
    .Enemy_Is_Attacked(A1), .Enemy_Is_Attacked2(A2),
    .Enemy_X(ex3), .Enemy_Y(ey3), .Enemy_Direction(edir3),
    .Enemy_Attack_On(aon3), .Enemy_Attack_Valid(aval3),
    .Enemy_State(est3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int absi(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Knockback moves opposite to the facing: down,left,up,right
  int kdx[4] = '{0, 1, 0, -1};
  int kdy[4] = '{-1, 0, 1, 0};

  task automatic model_clk();
    int dx, dy, kbv;
    bit inr, hit;
    if (Reset) begin
      ms = 0; mx = 16; my = 16; md = 0; mc = 0;
    end else if (!Alive) begin
      ms = 0; mx = 16; my = 16; mc = 0;
    end else if (tick) begin
      dx  = int'(PX) - mx;
      dy  = int'(PY) - my;
      inr = absi(dx) <= 20 && absi(dy) <= 20;
      hit = A1 || A2;
      kbv = A2 ? 16 : 8;
      if (ms != 0 && hit) begin
        mx = clampi(mx + kdx[md] * kbv, 16, 454);
        my = clampi(my + kdy[md] * kbv, 16, 294);
      end
      case (ms)
        0: ms = 1;
        1: begin
          if (inr) begin
            ms = 2; mc = 0;
          end else if (!hit) begin
            if (absi(dx) >= absi(dy)) begin
              mx = clampi(mx + (dx > 0 ? 1 : -1), 16, 454);
              md = (dx > 0) ? 3 : 1;
            end else begin
              my = clampi(my + (dy > 0 ? 1 : -1), 16, 294);
              md = (dy > 0) ? 0 : 2;
            end
          end
        end
        2: begin
          if (!inr || hit) begin
            ms = 1; mc = 0;
          end else if (mc == 7) ms = 3;
          else mc++;
        end
        3: begin
          ms = 4; mc = 0;
        end
        default: begin
          if (mc == 29) begin
            ms = 1; mc = 0;
          end else mc++;
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("x", ex, mx);
    chk("y", ey, my);
    chk("dir", edir, md);
    chk("state", est, ms);
    chk("valid", aval, ms == 3);
    chk("atk_on", aon, ms == 2 || ms == 3);
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_clk();
    #1;
    check_all();
  endtask

  task automatic tick1();
    int g;
    g = $urandom_range(0, 2);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    A1 = 1'b0;
    A2 = 1'b0;
    repeat (g) cyc();
  endtask

  task automatic respawn();
    Alive = 1'b0;
    cyc();
    Alive = 1'b1;
  endtask

  task automatic run_until(input string tag, input int st);
    int n;
    n = 0;
    while (ms != st && n < 400) begin
      tick1();
      n++;
    end
    chk(tag, est, st);
  endtask

  initial begin
    Reset = 1'b1; tick = 1'b0; Alive = 1'b0;
    A1 = 1'b0; A2 = 1'b0; PX = 9'd100; PY = 9'd16;
    cyc();
    cyc();
    chk("spawn3_x", ex3, 454);
    chk("spawn3_y", ey3, 294);
    chk("spawn3_st", est3, 0);
    Reset = 1'b0;

    repeat (5) tick1();
    chk("t1_x", ex, 16);
    chk("t1_st", est, 0);
    chk("t1_valid", aval, 0);

    Alive = 1'b1;
    tick1();
    chk("t2_st", est, 1);
    repeat (10) tick1();
    chk("t2_x", ex, 26);
    chk("t2_dir", edir, 3);

    respawn();
    PX = 9'd30; PY = 9'd20;
    tick1();
    tick1();
    chk("t3_windup", est, 2);
    repeat (7) tick1();
    chk("t3_still_wu", est, 2);
    tick1();
    chk("t3_strike", est, 3);
    chk("t3_valid", aval, 1);
    tick1();
    chk("t3_cool", est, 4);
    chk("t3_valid_off", aval, 0);
    repeat (29) tick1();
    chk("t3_cool_end", est, 4);
    tick1();
    chk("t3_chase", est, 1);

    respawn();
    PX = 9'd220; PY = 9'd16;
    run_until("t4_reach", 2);
    chk("t4_x0", ex, 200);
    chk("t4_dir", edir, 3);
    A1 = 1'b1;
    tick1();
    chk("t4_kb1", ex, 192);
    chk("t4_stagger", est, 1);
    run_until("t4_reach2", 2);
    A2 = 1'b1;
    tick1();
    chk("t4_kb2", ex, 184);
    run_until("t4_reach3", 2);
    A1 = 1'b1; A2 = 1'b1;
    tick1();
    chk("t4_kb_both", ex, 184);

    respawn();
    PX = 9'd40; PY = 9'd16;
    run_until("t5_reach", 2);
    chk("t5_x0", ex, 20);
    A2 = 1'b1;
    tick1();
    chk("t5_sat", ex, 16);

    respawn();
    PX = 9'd30; PY = 9'd20;
    run_until("t6_reach", 3);
    Alive = 1'b0;
    cyc();
    chk("t6_st", est, 0);
    chk("t6_valid", aval, 0);
    chk("t6_x", ex, 16);
    chk("t6_y", ey, 16);
    Alive = 1'b1;

    repeat (1500) begin
      if ($urandom_range(0, 199) == 0) begin
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
      end
      Alive = ($urandom_range(0, 99) < 97);
      PX = 9'(clampi(mx + int'($urandom_range(0, 70)) - 35, 0, 511));
      PY = 9'(clampi(my + int'($urandom_range(0, 70)) - 35, 0, 511));
      A1 = ($urandom_range(0, 9) == 0);
      A2 = ($urandom_range(0, 9) == 0);
      tick1();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/enemy_controller.md
Name: enemy_controller

Overview:
- Per-enemy motion and attack sequencer; one instance per enemy, indexed by `id`.
- Sits directly upstream of the enemy combat/damage stage.
- Drives that stage's Enemy_X, Enemy_Y and Enemy_Attack_Valid inputs.
- Consumes that stage's Enemy_Alive, Enemy_Is_Attacked and Enemy_Is_Attacked2 outputs.
- Chases the player, winds up, strikes, cools down and gets knocked back, all paced by the game frame tick.

Parameters:
id, 0, enemy index; selects spawn corner (id[1:0]: 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right)
X_MIN, 9'd16, left bound of enemy top-left X
X_MAX, 9'd454, right bound of enemy top-left X
Y_MIN, 9'd16, top bound of enemy top-left Y
Y_MAX, 9'd294, bottom bound of enemy top-left Y
STEP, 9'd1, pixels moved per frame while chasing
ATTACK_RANGE, 9'd20, max |dx| and max |dy| at which a windup starts
WINDUP_FRAMES, 6'd8, frames spent in WINDUP before the strike
COOLDOWN_FRAMES, 6'd30, frames spent in COOLDOWN after the strike
KNOCKBACK, 9'd8, displacement on Enemy_Is_Attacked; doubled on Enemy_Is_Attacked2

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous active-high reset
game_frame_clk_rising_edge  in  1  one-Clk pulse per game frame
Player_X  in  9  player top-left X
Player_Y  in  9  player top-left Y
Enemy_Alive  in  1  enemy alive flag from the combat stage
Enemy_Is_Attacked  in  1  melee hit this frame; meaningful only with the tick
Enemy_Is_Attacked2  in  1  special-attack hit this frame; meaningful only with the tick
Enemy_X  out  9  enemy top-left X (registered)
Enemy_Y  out  9  enemy top-left Y (registered)
Enemy_Direction  out  2  facing: 0 down, 1 left, 2 up, 3 right (registered)
Enemy_Attack_On  out  1  high in WINDUP and STRIKE; for sprite selection
Enemy_Attack_Valid  out  1  high exactly while state is STRIKE
Enemy_State  out  3  current state encoding; for debug

Behaviour:
- Clocking and reset:
  - One clock domain (Clk); Reset is synchronous and active-high.
  - Reset: state DEAD, Enemy_X/Enemy_Y = spawn corner, Enemy_Direction = 0, frame counter = 0. Enemy_Attack_On and Enemy_Attack_Valid therefore read 0.
  - Spawn corner: X = X_MIN if id[0]==0 else X_MAX; Y = Y_MIN if id[1]==0 else Y_MAX.
- State encodings: DEAD=0, CHASE=1, WINDUP=2, STRIKE=3, COOLDOWN=4.
- All outputs are registered state decodes; no combinational input-to-output path.
- Priority, highest first:
  1. Reset.
  2. Enemy_Alive==0: DEAD on the next Clk regardless of tick; position forced to spawn; counter cleared.
  3. Frame-tick actions below.
- Without a tick, and not dead, all registers hold.
- Arithmetic:
  - dx = Player_X − Enemy_X and dy = Player_Y − Enemy_Y, computed as 10-bit signed.
  - In range when |dx| ≤ ATTACK_RANGE and |dy| ≤ ATTACK_RANGE.
  - Every position update saturates to [X_MIN, X_MAX] / [Y_MIN, Y_MAX]; never wraps.
- On a tick, by state:
  - DEAD: if Enemy_Alive → CHASE at spawn position.
  - CHASE:
    - If in range → WINDUP, counter = 0, no move.
    - Else step STEP along the axis with larger |d|; tie picks X.
    - Enemy_Direction follows the step: +Y→0, −X→1, −Y→2, +X→3.
  - WINDUP:
    - If not in range → CHASE (cancel).
    - Else if counter == WINDUP_FRAMES−1 → STRIKE.
    - Else counter+1.
    - No movement.
  - STRIKE: → COOLDOWN, counter = 0. STRIKE therefore spans exactly one tick as seen downstream, giving exactly one damage event per strike.
  - COOLDOWN: if counter == COOLDOWN_FRAMES−1 → CHASE, else counter+1. No movement.
- Knockback (tick cycle, state ≠ DEAD):
  - Trigger: Enemy_Is_Attacked or Enemy_Is_Attacked2.
  - Displace opposite Enemy_Direction by KNOCKBACK (Attack2: 2×KNOCKBACK, saturated); saturate at bounds.
  - Both asserted together: apply Attack2 only.
  - Knockback overrides that tick's chase step.
  - WINDUP hit: additionally → CHASE (stagger).
  - STRIKE or COOLDOWN hit: the state transition still happens.
- Enemy_Alive falling mid-WINDUP/STRIKE: → DEAD next Clk; Enemy_Attack_Valid drops the same cycle.

Test Plan:
1. Reset, id=0, Enemy_Alive=0 for 5 ticks → Enemy_X=16, Enemy_Y=16, Enemy_State=0, Enemy_Attack_Valid=0.
2. Alive=1, player (100,16), enemy (16,16), STEP=1 → after 1 tick CHASE; after 10 more ticks Enemy_X=26, Direction=3.
3. Player (30,20), enemy in CHASE at (16,16) → tick1 WINDUP. After 8 more ticks STRIKE. Attack_Valid high across exactly one tick; then COOLDOWN for 30 ticks; then CHASE.
4. In WINDUP facing right at (200,100), Enemy_Is_Attacked on tick → Enemy_X=192, state CHASE. Same with Attack2 → Enemy_X=184. Both together → 184.
5. Enemy at (20,16) facing right, Attack2 hit → Enemy_X=16, saturated not wrapped.
6. Alive drops between ticks during STRIKE → next Clk State=0, Attack_Valid=0, position=spawn.
